// File: rtl/alarm_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller_if
// Description : Bundles the keypad, sensor and indicator signals of the
//               alarm controller.
//               master : drives tick/btn/check/code_cfg/zone/zone_mask and
//                        observes the indicators.
//               slave  : the controller itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_controller_if #(
    parameter int N_BTN    = 3,
    parameter int CODE_LEN = 4,
    parameter int N_ZONES  = 2
) ();
    localparam int c_bw = (N_BTN > 2) ? $clog2(N_BTN) : 1;

    logic                     tick;
    logic [N_BTN-1:0]         btn;
    logic                     check;
    logic [CODE_LEN*c_bw-1:0] code_cfg;
    logic [N_ZONES-1:0]       zone;
    logic [N_ZONES-1:0]       zone_mask;

    logic [2:0]               state;
    logic                     armed_led;
    logic                     alarm;
    logic [N_ZONES-1:0]       zone_latched;
    logic                     lockout;
    logic [3:0]               fail_cnt;

    modport master (
        output tick, btn, check, code_cfg, zone, zone_mask,
        input  state, armed_led, alarm, zone_latched, lockout, fail_cnt
    );

    modport slave (
        input  tick, btn, check, code_cfg, zone, zone_mask,
        output state, armed_led, alarm, zone_latched, lockout, fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Keypad-armed intrusion alarm. Collects a button code, arms
//               through an exit delay, trips through an entry delay into
//               ALARM on enabled zone activity, and locks the keypad after
//               MAX_FAIL consecutive wrong codes.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - alarm_controller_if.slave (tick, btn, check, code_cfg,
//                      zone, zone_mask in; state, armed_led, alarm,
//                      zone_latched, lockout, fail_cnt out; all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller #(
    parameter int N_BTN       = 3,
    parameter int CODE_LEN    = 4,
    parameter int N_ZONES     = 2,
    parameter int EXIT_TICKS  = 10,
    parameter int ENTRY_TICKS = 10,
    parameter int LOCK_TICKS  = 30,
    parameter int MAX_FAIL    = 3
) (
    input wire                clk,
    input wire                rst,
    alarm_controller_if.slave bus
);
    localparam int c_bw = (N_BTN > 2) ? $clog2(N_BTN) : 1;
    localparam int c_cw = $clog2(CODE_LEN + 2);   // holds 0..CODE_LEN+1

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    state_t                   r_state,    w_state_nxt;
    logic [7:0]               r_tmr,      w_tmr_nxt;
    logic [7:0]               r_ltmr,     w_ltmr_nxt;
    logic                     r_led,      w_led_nxt;
    logic                     r_alarm,    w_alarm_nxt;
    logic [N_ZONES-1:0]       r_zl,       w_zl_nxt;
    logic                     r_lockout,  w_lock_nxt;
    logic [3:0]               r_fail,     w_fail_nxt;
    logic [CODE_LEN*c_bw-1:0] r_buf,      w_buf_nxt;
    logic [c_cw-1:0]          r_cnt,      w_cnt_nxt;
    logic                     r_err,      w_err_nxt;
    logic [N_BTN-1:0]         r_btn_prev;
    logic                     r_chk_prev;

    logic [N_BTN-1:0]         w_btn_rise;
    logic                     w_chk_rise;
    logic                     w_btn_single;
    logic [c_bw-1:0]          w_btn_idx;
    logic                     w_valid;
    logic                     w_invalid;
    logic                     w_hit_max;
    logic [3:0]               w_fail_inc;
    logic [N_ZONES-1:0]       w_hits;

    assign w_btn_rise   = bus.btn & ~r_btn_prev;
    assign w_chk_rise   = bus.check & ~r_chk_prev;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_btn_single = (w_btn_rise != '0) &&
                          ((w_btn_rise & (w_btn_rise - N_BTN'(1))) == '0);
    assign w_fail_inc   = r_fail + 4'd1;
    assign w_hits       = bus.zone & bus.zone_mask;

    always_comb begin
        w_btn_idx   = '0;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_valid     = 1'b0;
        w_invalid   = 1'b0;
        w_fail_nxt  = r_fail;
        w_lock_nxt  = r_lockout;
        w_ltmr_nxt  = r_ltmr;
        w_hit_max   = 1'b0;
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_zl_nxt    = r_zl;
        w_led_nxt   = 1'b0;
        w_alarm_nxt = 1'b0;

        for (int i = 0; i < N_BTN; i++) begin
            if (w_btn_rise[i]) begin
                w_btn_idx = c_bw'(i);
            end
        end

        // Keypad entry; every edge is ignored while locked out. A check edge
        // wins over any button edge in the same cycle.
        if (!r_lockout) begin
            if (w_chk_rise) begin
                if ((r_cnt == c_cw'(CODE_LEN)) && !r_err && (r_buf == bus.code_cfg)) begin
                    w_valid = 1'b1;
                end else begin
                    w_invalid = 1'b1;
                end
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
                w_err_nxt = 1'b0;
            end else if (w_btn_rise != '0) begin
                if (w_btn_single) begin
                    if (r_cnt < c_cw'(CODE_LEN)) begin
                        w_buf_nxt[int'(r_cnt)*c_bw +: c_bw] = w_btn_idx;
                    end
                    if (r_cnt <= c_cw'(CODE_LEN)) begin
                        w_cnt_nxt = r_cnt + c_cw'(1);
                    end
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
        end

        // Failure counting and keypad lockout.
        if (r_lockout) begin
            if (bus.tick) begin
                if (r_ltmr <= 8'd1) begin
                    w_lock_nxt = 1'b0;
                    w_fail_nxt = 4'd0;
                    w_ltmr_nxt = 8'd0;
                end else begin
                    w_ltmr_nxt = r_ltmr - 8'd1;
                end
            end
        end else if (w_valid) begin
            w_fail_nxt = 4'd0;
        end else if (w_invalid && (r_fail != 4'hF)) begin
            w_fail_nxt = w_fail_inc;
            if (w_fail_inc == 4'(MAX_FAIL)) begin
                w_lock_nxt = 1'b1;
                w_ltmr_nxt = 8'(LOCK_TICKS);
                w_hit_max  = 1'b1;
            end
        end

        if ((r_state == ST_ARMED) || (r_state == ST_ENTRY) || (r_state == ST_ALARM)) begin
            w_zl_nxt = r_zl | w_hits;
        end

        // Valid check outranks lockout, zone trips and timer expiry.
        case (r_state)
            ST_DISARMED: begin
                if (w_valid) begin
                    w_state_nxt = ST_EXIT;
                    w_tmr_nxt   = 8'(EXIT_TICKS);
                    w_zl_nxt    = '0;
                end
            end
            ST_EXIT: begin
                if (w_valid) begin
                    w_state_nxt = ST_DISARMED;
                    w_tmr_nxt   = 8'd0;
                end else if (bus.tick) begin
                    if (r_tmr <= 8'd1) begin
                        w_state_nxt = ST_ARMED;
                        w_tmr_nxt   = 8'd0;
                    end else begin
                        w_tmr_nxt = r_tmr - 8'd1;
                    end
                end
            end
            ST_ARMED: begin
                if (w_valid) begin
                    w_state_nxt = ST_DISARMED;
                end else if (w_hit_max) begin
                    w_state_nxt = ST_ALARM;
                end else if (w_hits != '0) begin
                    w_state_nxt = ST_ENTRY;
                    w_tmr_nxt   = 8'(ENTRY_TICKS);
                end
            end
            ST_ENTRY: begin
                if (w_valid) begin
                    w_state_nxt = ST_DISARMED;
                    w_tmr_nxt   = 8'd0;
                end else if (w_hit_max) begin
                    w_state_nxt = ST_ALARM;
                    w_tmr_nxt   = 8'd0;
                end else if (bus.tick) begin
                    if (r_tmr <= 8'd1) begin
                        w_state_nxt = ST_ALARM;
                        w_tmr_nxt   = 8'd0;
                    end else begin
                        w_tmr_nxt = r_tmr - 8'd1;
                    end
                end
            end
            ST_ALARM: begin
                if (w_valid) begin
                    w_state_nxt = ST_DISARMED;
                end
            end
            default: begin
                w_state_nxt = ST_DISARMED;
                w_tmr_nxt   = 8'd0;
            end
        endcase

        // LED blinks through the exit delay, starting lit on entry.
        case (w_state_nxt)
            ST_DISARMED: w_led_nxt = 1'b0;
            ST_EXIT:     w_led_nxt = (r_state != ST_EXIT) ? 1'b1 :
                                     (bus.tick ? ~r_led : r_led);
            default:     w_led_nxt = 1'b1;
        endcase
        w_alarm_nxt = (w_state_nxt == ST_ALARM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_DISARMED;
            r_tmr      <= 8'd0;
            r_ltmr     <= 8'd0;
            r_led      <= 1'b0;
            r_alarm    <= 1'b0;
            r_zl       <= '0;
            r_lockout  <= 1'b0;
            r_fail     <= 4'd0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_btn_prev <= '0;
            r_chk_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_ltmr     <= w_ltmr_nxt;
            r_led      <= w_led_nxt;
            r_alarm    <= w_alarm_nxt;
            r_zl       <= w_zl_nxt;
            r_lockout  <= w_lock_nxt;
            r_fail     <= w_fail_nxt;
            r_buf      <= w_buf_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_btn_prev <= bus.btn;
            r_chk_prev <= bus.check;
        end
    end

    assign bus.state        = r_state;
    assign bus.armed_led    = r_led;
    assign bus.alarm        = r_alarm;
    assign bus.zone_latched = r_zl;
    assign bus.lockout      = r_lockout;
    assign bus.fail_cnt     = r_fail;
endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_controller
// Description : Self-checking bench for alarm_controller: a vector table for
//               the basic arm/trip/disarm flow, directed multi-cycle corner
//               sequences, and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;
    localparam int N_BTN       = 3;
    localparam int CODE_LEN    = 4;
    localparam int N_ZONES     = 2;
    localparam int EXIT_TICKS  = 10;
    localparam int ENTRY_TICKS = 10;
    localparam int LOCK_TICKS  = 30;
    localparam int MAX_FAIL    = 3;
    localparam int BW          = 2;
    localparam logic [7:0] c_correct = 8'h24;  // digits 0,1,2,0
    localparam logic [7:0] c_wrong   = 8'h55;  // digits 1,1,1,1

    logic clk = 1'b0;
    logic rst;

    alarm_controller_if #(.N_BTN(N_BTN), .CODE_LEN(CODE_LEN), .N_ZONES(N_ZONES)) ifc ();

    alarm_controller #(
        .N_BTN(N_BTN), .CODE_LEN(CODE_LEN), .N_ZONES(N_ZONES),
        .EXIT_TICKS(EXIT_TICKS), .ENTRY_TICKS(ENTRY_TICKS),
        .LOCK_TICKS(LOCK_TICKS), .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural reference model ----------------
    int         m_state, m_timer, m_lock_left, m_fail;
    bit         m_lock, m_err;
    logic [1:0] m_zl;
    int         m_digits[$];
    logic [2:0] m_prev_btn;
    logic       m_prev_chk;

    task automatic model_reset();
        m_state = 0; m_timer = 0; m_lock_left = 0; m_fail = 0;
        m_lock = 0; m_err = 0; m_zl = 2'b00; m_digits.delete();
        m_prev_btn = 3'b000; m_prev_chk = 1'b0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_clock();
        int         old_state = m_state;
        bit         lock_old  = m_lock;
        int         nrise = 0;
        int         last  = 0;
        bit         chk, valid, invalid, hit_max;
        logic [1:0] hits = ifc.zone & ifc.zone_mask;
        for (int i = 0; i < N_BTN; i++) begin
            if (ifc.btn[i] && !m_prev_btn[i]) begin
                nrise++;
                last = i;
            end
        end
        chk = ifc.check && !m_prev_chk;
        m_prev_btn = ifc.btn;
        m_prev_chk = ifc.check;
        valid = 0; invalid = 0; hit_max = 0;
        if (!lock_old) begin
            if (chk) begin
                valid = (m_digits.size() == CODE_LEN) && !m_err;
                if (valid) begin
                    for (int d = 0; d < CODE_LEN; d++) begin
                        if (m_digits[d] != int'(ifc.code_cfg[d*BW +: BW])) valid = 0;
                    end
                end
                invalid = !valid;
                m_digits.delete();
                m_err = 0;
            end else if (nrise == 1) begin
                if (m_digits.size() <= CODE_LEN) m_digits.push_back(last);
            end else if (nrise > 1) begin
                m_err = 1;
            end
        end
        if (lock_old) begin
            if (ifc.tick) begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    m_lock = 0;
                    m_fail = 0;
                end
            end
        end else if (valid) begin
            m_fail = 0;
        end else if (invalid && m_fail < 15) begin
            m_fail++;
            if (m_fail == MAX_FAIL) begin
                m_lock = 1;
                m_lock_left = LOCK_TICKS;
                hit_max = 1;
            end
        end
        if (old_state >= 2) m_zl = m_zl | hits;
        case (old_state)
            0: if (valid) begin m_state = 1; m_timer = EXIT_TICKS; m_zl = 2'b00; end
            1: if (valid) m_state = 0;
               else if (ifc.tick) begin
                   m_timer--;
                   if (m_timer == 0) m_state = 2;
               end
            2: if (valid) m_state = 0;
               else if (hit_max) m_state = 4;
               else if (hits != 2'b00) begin m_state = 3; m_timer = ENTRY_TICKS; end
            3: if (valid) m_state = 0;
               else if (hit_max) m_state = 4;
               else if (ifc.tick) begin
                   m_timer--;
                   if (m_timer == 0) m_state = 4;
               end
            default: if (valid) m_state = 0;
        endcase
    endtask

    function automatic logic [11:0] model_pack();
        logic led;
        if (m_state >= 2)      led = 1'b1;
        else if (m_state == 1) led = (((EXIT_TICKS - m_timer) % 2) == 0);
        else                   led = 1'b0;
        return {3'(m_state), led, (m_state == 4), m_zl, m_lock, 4'(m_fail)};
    endfunction

    function automatic logic [11:0] exp_pack(int st, bit led, bit al, logic [1:0] zl, bit lk, int fl);
        return {3'(st), led, al, zl, lk, 4'(fl)};
    endfunction

    // ---------------- checking ----------------
    task automatic check_out(string name, logic [11:0] exp);
        logic [11:0] g = {ifc.state, ifc.armed_led, ifc.alarm, ifc.zone_latched,
                          ifc.lockout, ifc.fail_cnt};
        n_checks++;
        if (g !== exp) begin
            n_fail++;
            $display("FAIL %s: state/led/alarm/zl/lock/fail got %0d/%0b/%0b/%b/%0b/%0d required %0d/%0b/%0b/%b/%0b/%0d",
                     name, g[11:9], g[8], g[7], g[6:5], g[4], g[3:0],
                     exp[11:9], exp[8], exp[7], exp[6:5], exp[4], exp[3:0]);
        end
    endtask

    task automatic cycle();
        if (rst) model_reset();
        else     model_clock();
        @(posedge clk);
        #1;
        check_out("model", model_pack());
    endtask

    // ---------------- directed helpers ----------------
    task automatic press(input logic [2:0] mask);
        ifc.btn = mask;   cycle();
        ifc.btn = 3'b000; cycle();
    endtask

    task automatic enter_digits(input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) press(3'b001 << code[2*i +: 2]);
    endtask

    task automatic do_check();
        ifc.check = 1'b1; cycle();
        ifc.check = 1'b0; cycle();
    endtask

    task automatic ticks(input int n);
        ifc.tick = 1'b1;
        repeat (n) cycle();
        ifc.tick = 1'b0;
    endtask

    task automatic arm();
        enter_digits(c_correct, 4);
        do_check();
        ticks(EXIT_TICKS);
    endtask

    // ---------------- random helpers ----------------
    task automatic rcycle();
        ifc.tick = ($urandom_range(0, 2) == 0);
        ifc.zone = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        cycle();
    endtask

    task automatic rpress(input logic [2:0] mask);
        ifc.btn = mask;   rcycle();
        ifc.btn = 3'b000; rcycle();
    endtask

    task automatic rcheck();
        ifc.check = 1'b1; rcycle();
        ifc.check = 1'b0; rcycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         reps;
        logic [2:0] btn;
        logic       chk;
        logic       tk;
        logic [1:0] zn;
        logic [1:0] zm;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int reps, logic [2:0] b, logic c, logic t,
                                logic [1:0] zn, logic [1:0] zm, logic [11:0] e);
        vec_t v;
        v.reps = reps; v.btn = b; v.chk = c; v.tk = t; v.zn = zn; v.zm = zm; v.exp = e;
        return v;
    endfunction

    task automatic add_code_rows(input logic [11:0] e);
        logic [7:0] code = c_correct;
        for (int d = 0; d < 4; d++) begin
            vecs.push_back(mk(1, 3'b001 << code[2*d +: 2], 0, 0, 2'b00, 2'b11, e));
            vecs.push_back(mk(1, 3'b000, 0, 0, 2'b00, 2'b11, e));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int act;
        rst           = 1'b1;
        ifc.tick      = 1'b0;
        ifc.btn       = 3'b000;
        ifc.check     = 1'b0;
        ifc.code_cfg  = c_correct;
        ifc.zone      = 2'b00;
        ifc.zone_mask = 2'b11;
        model_reset();
        #1;
        check_out("reset_async", exp_pack(0, 0, 0, 2'b00, 0, 0));
        cycle();
        cycle();
        check_out("reset_held", exp_pack(0, 0, 0, 2'b00, 0, 0));
        rst = 1'b0;

        // Arm, trip zone 0, let the entry delay expire, disarm.
        add_code_rows(exp_pack(0, 0, 0, 2'b00, 0, 0));
        vecs.push_back(mk(1, 3'b000, 1, 0, 2'b00, 2'b11, exp_pack(1, 1, 0, 2'b00, 0, 0)));
        vecs.push_back(mk(9, 3'b000, 0, 1, 2'b00, 2'b11, exp_pack(1, 0, 0, 2'b00, 0, 0)));
        vecs.push_back(mk(1, 3'b000, 0, 1, 2'b00, 2'b11, exp_pack(2, 1, 0, 2'b00, 0, 0)));
        vecs.push_back(mk(1, 3'b000, 0, 0, 2'b01, 2'b11, exp_pack(3, 1, 0, 2'b01, 0, 0)));
        vecs.push_back(mk(9, 3'b000, 0, 1, 2'b00, 2'b11, exp_pack(3, 1, 0, 2'b01, 0, 0)));
        vecs.push_back(mk(1, 3'b000, 0, 1, 2'b00, 2'b11, exp_pack(4, 1, 1, 2'b01, 0, 0)));
        add_code_rows(exp_pack(4, 1, 1, 2'b01, 0, 0));
        vecs.push_back(mk(1, 3'b000, 1, 0, 2'b00, 2'b11, exp_pack(0, 0, 0, 2'b01, 0, 0)));
        vecs.push_back(mk(1, 3'b000, 0, 0, 2'b00, 2'b11, exp_pack(0, 0, 0, 2'b01, 0, 0)));

        for (int v = 0; v < vecs.size(); v++) begin
            ifc.btn       = vecs[v].btn;
            ifc.check     = vecs[v].chk;
            ifc.tick      = vecs[v].tk;
            ifc.zone      = vecs[v].zn;
            ifc.zone_mask = vecs[v].zm;
            repeat (vecs[v].reps) cycle();
            check_out($sformatf("vec%0d", v), vecs[v].exp);
        end
        ifc.tick = 1'b0;

        // Masked-off zone does not trip or latch.
        arm();
        check_out("armed", exp_pack(2, 1, 0, 2'b00, 0, 0));
        ifc.zone = 2'b10; ifc.zone_mask = 2'b01;
        repeat (3) cycle();
        check_out("masked_zone", exp_pack(2, 1, 0, 2'b00, 0, 0));
        ifc.zone = 2'b00; ifc.zone_mask = 2'b11;

        // Valid check coinciding with the final entry tick disarms.
        ifc.zone = 2'b01; cycle(); ifc.zone = 2'b00;
        check_out("entry_trip", exp_pack(3, 1, 0, 2'b01, 0, 0));
        ticks(ENTRY_TICKS - 1);
        enter_digits(c_correct, 4);
        check_out("entry_hold", exp_pack(3, 1, 0, 2'b01, 0, 0));
        ifc.check = 1'b1; ifc.tick = 1'b1; cycle();
        check_out("check_vs_expiry", exp_pack(0, 0, 0, 2'b01, 0, 0));
        ifc.check = 1'b0; ifc.tick = 1'b0; cycle();
        check_out("check_vs_expiry_after", exp_pack(0, 0, 0, 2'b01, 0, 0));

        // Three wrong checks in ARMED -> lockout and ALARM.
        arm();
        enter_digits(c_correct, 3);
        do_check();
        check_out("wrong_short", exp_pack(2, 1, 0, 2'b00, 0, 1));
        press(3'b001); press(3'b010); press(3'b011); press(3'b100); press(3'b001);
        do_check();
        check_out("wrong_multi", exp_pack(2, 1, 0, 2'b00, 0, 2));
        enter_digits(c_wrong, 4);
        do_check();
        check_out("lockout_alarm", exp_pack(4, 1, 1, 2'b00, 1, 3));
        enter_digits(c_correct, 4);
        do_check();
        check_out("locked_ignore", exp_pack(4, 1, 1, 2'b00, 1, 3));
        ticks(LOCK_TICKS - 1);
        check_out("lock_last_tick", exp_pack(4, 1, 1, 2'b00, 1, 3));
        ticks(1);
        check_out("lock_release", exp_pack(4, 1, 1, 2'b00, 0, 0));
        enter_digits(c_correct, 4);
        do_check();
        check_out("disarm_after_lock", exp_pack(0, 0, 0, 2'b00, 0, 0));

        // Reset in the middle of the exit delay with a partial entry.
        enter_digits(c_correct, 4);
        do_check();
        ticks(3);
        check_out("exit_blink", exp_pack(1, 0, 0, 2'b00, 0, 0));
        press(3'b001); press(3'b010);
        rst = 1'b1;
        model_reset();
        #1;
        check_out("mid_reset", exp_pack(0, 0, 0, 2'b00, 0, 0));
        cycle();
        rst = 1'b0;
        enter_digits(c_correct, 4);
        do_check();
        check_out("after_reset_arm", exp_pack(1, 1, 0, 2'b00, 0, 0));

        // Randomized traffic; the model is compared every cycle.
        for (int it = 0; it < 1500; it++) begin
            act = $urandom_range(0, 9);
            ifc.zone_mask = 2'($urandom_range(0, 3));
            case (act)
                0, 1, 2: begin
                    for (int d = 0; d < 4; d++) rpress(3'b001 << ifc.code_cfg[2*d +: 2]);
                    rcheck();
                end
                3: begin
                    for (int d = 0; d < 4; d++) rpress(3'b001 << $urandom_range(0, 2));
                    rcheck();
                end
                4: begin
                    ifc.btn   = 3'($urandom_range(0, 7));
                    ifc.check = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 3)) rcycle();
                    ifc.btn = 3'b000; ifc.check = 1'b0;
                    rcycle();
                end
                5: rcheck();
                6: begin
                    if ($urandom_range(0, 7) == 0) begin
                        rst = 1'b1;
                        model_reset();
                        #1;
                        check_out("rand_reset", exp_pack(0, 0, 0, 2'b00, 0, 0));
                        cycle();
                        rst = 1'b0;
                    end else begin
                        repeat ($urandom_range(1, 10)) rcycle();
                    end
                end
                default: repeat ($urandom_range(5, 40)) rcycle();
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
